reg_bank_writer: RTL and testbench
==================================

// Module: reg_bank_writer
// PURPOSE
//  Write side of the processor register bank: accepts {dest, data} write requests from the
//  16-bit datapath bus and commits each into one of eight registers R0..R7. R0..R7 drive the
//  8-to-1 read-select mux directly. A small FIFO lets the datapath issue back-to-back writes
//  while commits are stalled by Hold (e.g. during a multi-cycle instruction).
// PARAMETERS
//  WIDTH   16  data width of bus and each register
//  DEPTH   2   write-buffer entries; power of two, 2..8
// PORTS
//  Clock    in   1      single clock; all state updates on rising edge
//  Reset    in   1      synchronous, active-high; sampled on rising Clock edge
//  BusIn    in   WIDTH  write data
//  Dest     in   3      destination register index (0..7)
//  WrValid  in   1      write request present this cycle
//  WrReady  out  1      buffer can accept; transfer occurs on edge with WrValid&WrReady
//  Hold     in   1      1 = suppress commits this cycle (buffer keeps filling)
//  Incr     in   1      R7 increment request; ignored unless PC_AUTOINC_EN defined
//  Pending  out  4      number of buffered, uncommitted writes (0..DEPTH)
//  R0..R7   out  WIDTH  register contents, one port per register, registered outputs
// BEHAVIOUR
//  - Reset (edge with Reset=1): R0..R7=0, Pending=0, FIFO pointers=0, buffered writes dropped.
//    While Reset=1, WrReady=0 combinationally and WrValid is ignored. Reset mid-burst: all
//    uncommitted entries lost; nothing partially written.
//  - WrReady = !Reset && (Pending < DEPTH). Depends on state only, never on WrValid/Hold.
//  - Accept: on edge with WrValid&WrReady, {Dest,BusIn} pushed at tail.
//  - Commit: on edge with Pending>0 && !Hold, head popped, R[head.dest] <= head.data.
//    Max one commit per cycle; other registers unchanged.
//  - Latency: write accepted at edge N with empty buffer and Hold=0 at N+1 -> register
//    updated at edge N+1 (visible after N+1). No bypass path from BusIn to R0..R7.
//  - Ordering: strict FIFO; two writes to same Dest -> later value wins.
//  - Simultaneous accept+commit: Pending unchanged. When full, WrReady=0 even if a commit
//    occurs that edge (no pass-through); accept resumes next cycle.
//  - Pending: +1 accept only, -1 commit only, else unchanged. Pointers wrap modulo DEPTH.
//  - Hold=1 with full buffer: WrReady=0 indefinitely; no state change except via Incr.
//  - Dest is 3 bits: all codes valid, no error path.
// CONFIGURATION
//  PC_AUTOINC_EN defined:
//   - R7 acts as program counter: on edge with Incr=1, R7 <= R7+1 (mod 2^WIDTH, wraps
//     FFFF->0000 for WIDTH=16).
//   - Same edge commit to R7 and Incr=1: commit wins, increment discarded.
//   - Incr ignored while Reset=1.
//  PC_AUTOINC_EN not defined: Incr ignored entirely; R7 is an ordinary register.
// TESTING
//  1 Reset: assert Reset 2 cycles mid-traffic -> R0..R7=0, Pending=0, WrReady=0 during,
//    WrReady=1 the cycle after release.
//  2 Single write: Dest=3, BusIn=16'hA5A5, Hold=0 at edge N -> R3=A5A5 after edge N+1,
//    others 0, Pending 1 then 0.
//  3 Back-pressure: Hold=1, writes R1=0011, R2=0022 -> Pending=2, WrReady=0, R1/R2 still 0;
//    drop Hold -> R1=0011 after next edge, R2=0022 after following edge.
//  4 Same-dest order: Hold=1, write R5=1111 then R5=2222, release Hold -> final R5=2222.
//  5 Reset with Pending=2 (Hold=1) -> entries discarded; after release, no register changes.
//  6 PC_AUTOINC_EN: R7=FFFE, Incr=1 two cycles -> FFFF then 0000; commit R7=1234 with
//    Incr=1 same edge -> R7=1234. Without macro: Incr=1 leaves R7 unchanged.

Source files
------------

// File: rtl/reg_bank_writer.sv
// Write side of the register bank: a small write buffer in front of eight registers R0..R7.
// Optional R7 program-counter auto-increment is enabled by defining PC_AUTOINC_EN.
module reg_bank_writer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] bus_in_i,
   input  logic [2:0]       dest_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic             hold_i,
   input  logic             incr_i,
   output logic [3:0]       pending_o,
   output logic [WIDTH-1:0] r0_o,
   output logic [WIDTH-1:0] r1_o,
   output logic [WIDTH-1:0] r2_o,
   output logic [WIDTH-1:0] r3_o,
   output logic [WIDTH-1:0] r4_o,
   output logic [WIDTH-1:0] r5_o,
   output logic [WIDTH-1:0] r6_o,
   output logic [WIDTH-1:0] r7_o
);

   localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   typedef struct packed {
      logic [2:0]       dest;
      logic [WIDTH-1:0] data;
   } wr_entry_t;

   wr_entry_t        buf_q  [DEPTH];
   wr_entry_t        buf_d  [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] regs_q [8];
   logic [WIDTH-1:0] regs_d [8];

   logic      accept;
   logic      commit;
   wr_entry_t head;

   // Ready is a function of state and reset only, so a full buffer never passes through.
   assign wr_ready_o = !reset_i && (cnt_q < DEPTH_C);
   assign accept     = wr_valid_i && wr_ready_o;
   assign commit     = (cnt_q != 4'd0) && !hold_i;
   assign head       = buf_q[rd_ptr_q];

   always_comb begin
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      regs_d   = regs_q;

`ifdef PC_AUTOINC_EN
      // A commit to R7 on the same edge overrides the increment.
      if (incr_i)
         regs_d[7] = regs_q[7] + WIDTH'(1);
`endif

      if (commit) begin
         regs_d[head.dest] = head.data;
         rd_ptr_d          = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end

      if (accept) begin
         buf_d[wr_ptr_q] = '{dest: dest_i, data: bus_in_i};
         wr_ptr_d        = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end

      case ({accept, commit})
         2'b10:   cnt_d = cnt_q + 4'd1;
         2'b01:   cnt_d = cnt_q - 4'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < 8; i++)
            regs_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++)
            buf_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         regs_q   <= regs_d;
         buf_q    <= buf_d;
      end
   end

`ifndef PC_AUTOINC_EN
   logic unused_incr;
   assign unused_incr = incr_i;
`endif

   assign pending_o = cnt_q;
   assign r0_o      = regs_q[0];
   assign r1_o      = regs_q[1];
   assign r2_o      = regs_q[2];
   assign r3_o      = regs_q[3];
   assign r4_o      = regs_q[4];
   assign r5_o      = regs_q[5];
   assign r6_o      = regs_q[6];
   assign r7_o      = regs_q[7];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Bench for reg_bank_writer: directed scenarios plus random traffic against a queue-based model.
module tb_reg_bank_writer;

   localparam int WIDTH = 16;
   localparam int DEPTH = 2;

   logic             clk_i = 1'b0;
   logic             reset_i, wr_valid_i, hold_i, incr_i, wr_ready_o;
   logic [WIDTH-1:0] bus_in_i;
   logic [2:0]       dest_i;
   logic [3:0]       pending_o;
   logic [WIDTH-1:0] r0_o, r1_o, r2_o, r3_o, r4_o, r5_o, r6_o, r7_o;
   logic [WIDTH-1:0] rv [8];

   always #5 clk_i = ~clk_i;

   reg_bank_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .bus_in_i(bus_in_i), .dest_i(dest_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .hold_i(hold_i), .incr_i(incr_i),
      .pending_o(pending_o),
      .r0_o(r0_o), .r1_o(r1_o), .r2_o(r2_o), .r3_o(r3_o),
      .r4_o(r4_o), .r5_o(r5_o), .r6_o(r6_o), .r7_o(r7_o)
   );

   assign rv[0] = r0_o; assign rv[1] = r1_o; assign rv[2] = r2_o; assign rv[3] = r3_o;
   assign rv[4] = r4_o; assign rv[5] = r5_o; assign rv[6] = r6_o; assign rv[7] = r7_o;

   typedef struct packed {
      logic [2:0]       d;
      logic [WIDTH-1:0] v;
   } wr_t;

   int               nvec = 0;
   int               nerr = 0;
   logic [WIDTH-1:0] mreg [8];
   wr_t              mq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, compare outputs with the model, then advance the model across the edge.
   task automatic cycle(input logic rst, input logic v, input logic [2:0] d,
                        input logic [WIDTH-1:0] data, input logic h, input logic inc);
      logic acc, com;
      wr_t  e;
      @(negedge clk_i);
      reset_i = rst; wr_valid_i = v; dest_i = d; bus_in_i = data; hold_i = h; incr_i = inc;
      #1;
      for (int i = 0; i < 8; i++)
         chk($sformatf("R%0d", i), 32'(rv[i]), 32'(mreg[i]));
      chk("pending", 32'(pending_o), 32'(mq.size()));
      chk("wr_ready", 32'(wr_ready_o), 32'(!rst && mq.size() < DEPTH));
      e = '0;
      if (rst) begin
         mq.delete();
         for (int i = 0; i < 8; i++) mreg[i] = '0;
      end else begin
         acc = v && (mq.size() < DEPTH);
         com = (mq.size() > 0) && !h;
         if (com) begin
            e = mq.pop_front();
            mreg[e.d] = e.v;
         end
`ifdef PC_AUTOINC_EN
         if (inc && !(com && e.d == 3'd7)) mreg[7] = mreg[7] + 1'b1;
`endif
         if (acc) mq.push_back('{d: d, v: data});
      end
   endtask

   task automatic idle(input logic h);
      cycle(1'b0, 1'b0, 3'd0, '0, h, 1'b0);
   endtask

   initial begin
      reset_i = 1'b1; wr_valid_i = 1'b0; dest_i = '0; bus_in_i = '0; hold_i = 1'b0; incr_i = 1'b0;
      repeat (2) @(posedge clk_i);
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      cycle(1'b1, 1'b1, 3'd4, 16'hDEAD, 1'b0, 1'b1);
      chk("rst_ready", 32'(wr_ready_o), 32'd0);

      // Single write: committed one edge after acceptance.
      cycle(1'b0, 1'b1, 3'd3, 16'hA5A5, 1'b0, 1'b0);
      idle(1'b0);
      chk("t2_pend1", 32'(pending_o), 32'd1);
      chk("t2_r3_old", 32'(r3_o), 32'd0);
      idle(1'b0);
      chk("t2_r3", 32'(r3_o), 32'hA5A5);
      chk("t2_pend0", 32'(pending_o), 32'd0);

      // Back-pressure with Hold.
      cycle(1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 3'd2, 16'h0022, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 3'd6, 16'h0066, 1'b1, 1'b0);
      chk("t3_full", 32'(wr_ready_o), 32'd0);
      chk("t3_pend", 32'(pending_o), 32'd2);
      chk("t3_r1_held", 32'(r1_o), 32'd0);
      idle(1'b0);
      idle(1'b0);
      chk("t3_r1", 32'(r1_o), 32'h0011);
      chk("t3_r2_old", 32'(r2_o), 32'd0);
      idle(1'b0);
      chk("t3_r2", 32'(r2_o), 32'h0022);
      chk("t3_r6", 32'(r6_o), 32'd0);

      // Same destination twice: later write wins.
      cycle(1'b0, 1'b1, 3'd5, 16'h1111, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 3'd5, 16'h2222, 1'b1, 1'b0);
      repeat (3) idle(1'b0);
      chk("t4_r5", 32'(r5_o), 32'h2222);

      // Reset with a full buffer discards everything.
      cycle(1'b0, 1'b1, 3'd0, 16'hBEEF, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 3'd1, 16'hCAFE, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 3'd2, 16'h1234, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0);
      idle(1'b0);
      chk("t5_ready", 32'(wr_ready_o), 32'd1);
      repeat (2) idle(1'b0);
      chk("t5_r0", 32'(r0_o), 32'd0);
      chk("t5_r1", 32'(r1_o), 32'd0);

      // R7 increment behaviour.
      cycle(1'b0, 1'b1, 3'd7, 16'hFFFE, 1'b0, 1'b0);
      idle(1'b0);
      cycle(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
`ifdef PC_AUTOINC_EN
      chk("t6_r7_ffff", 32'(r7_o), 32'hFFFF);
      idle(1'b0);
      chk("t6_r7_wrap", 32'(r7_o), 32'h0000);
      cycle(1'b0, 1'b1, 3'd7, 16'h1234, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
      idle(1'b0);
      chk("t6_r7_commit", 32'(r7_o), 32'h1234);
`else
      idle(1'b0);
      chk("t6_r7_noinc", 32'(r7_o), 32'hFFFE);
`endif

      // Random traffic with bursty Hold and occasional reset.
      for (int n = 0; n < 400; n++) begin
         logic h;
         h = ($urandom_range(0, 99) < ((n / 40) % 2 == 1 ? 80 : 30));
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 65),
               3'($urandom_range(0, 7)), WIDTH'($urandom), h,
               ($urandom_range(0, 99) < 30));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
